// File: rtl/timer_multi.sv
// Multi-channel down-counting timer with a small register file per channel.
// Each channel runs IDLE/LOAD/CNT/DONE and raises a sticky PEND when its count expires.
module timer_multi #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:2]        PrAddr,
   input  logic              Wr_en,
   input  logic [31:0]       Data_in,
   output logic [31:0]       Data_out,
   output logic              IRQ,
   output logic [NUM_CH-1:0] IRQ_vec
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, DONE} state_e;

   localparam logic [1:0] SEL_CTRL    = 2'd0;
   localparam logic [1:0] SEL_PRESET  = 2'd1;
   localparam logic [1:0] SEL_COUNT   = 2'd2;
   localparam logic [1:0] SEL_STAT    = 2'd3;
   localparam logic [1:0] MODE_RELOAD = 2'b01;
   localparam logic [1:0] MODE_FREE   = 2'b10;

   logic [1:0]       ch_sel;
   logic [1:0]       reg_sel;
   logic [NUM_CH-1:0] wr_ch;

   state_e           state_q  [NUM_CH];
   logic [3:0]       ctrl_q   [NUM_CH];
   logic [CNT_W-1:0] preset_q [NUM_CH];
   logic [CNT_W-1:0] count_q  [NUM_CH];
   logic [NUM_CH-1:0] pend_q;

   // Upper data bits are unused when CNT_W < 32.
   logic data_unused;
   assign data_unused = ^Data_in;

   assign ch_sel  = PrAddr[5:4];
   assign reg_sel = PrAddr[3:2];

   always_comb begin
      wr_ch = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         wr_ch[c] = Wr_en && (ch_sel == 2'(c));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= IDLE;
            ctrl_q[c]   <= '0;
            preset_q[c] <= '0;
            count_q[c]  <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            // Clear is scheduled first so a hardware set later in this block wins.
            if (wr_ch[c] && reg_sel == SEL_STAT && Data_in[0]) begin
               pend_q[c] <= 1'b0;
            end
            case (state_q[c])
               IDLE: begin
                  if (ctrl_q[c][0]) state_q[c] <= LOAD;
               end
               LOAD: begin
                  count_q[c] <= preset_q[c];
                  state_q[c] <= CNT;
               end
               CNT: begin
                  if (!ctrl_q[c][0]) begin
                     state_q[c] <= IDLE;
                  end else if (count_q[c] != '0) begin
                     count_q[c] <= count_q[c] - CNT_W'(1);
                  end else begin
                     pend_q[c] <= 1'b1;
                     if (ctrl_q[c][2:1] == MODE_FREE) count_q[c] <= '1;
                     else                             state_q[c] <= DONE;
                  end
               end
               DONE: begin
                  if (ctrl_q[c][2:1] == MODE_RELOAD) begin
                     state_q[c] <= LOAD;
                  end else begin
                     ctrl_q[c][0] <= 1'b0;
                     state_q[c]   <= IDLE;
                  end
               end
               default: state_q[c] <= IDLE;
            endcase
            // A CPU CTRL write overrides the one-shot EN clear issued above.
            if (wr_ch[c] && reg_sel == SEL_CTRL)   ctrl_q[c]   <= Data_in[3:0];
            if (wr_ch[c] && reg_sel == SEL_PRESET) preset_q[c] <= Data_in[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      Data_out = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (ch_sel == 2'(c)) begin
            case (reg_sel)
               SEL_CTRL:   Data_out = {28'b0, ctrl_q[c]};
               SEL_PRESET: Data_out = 32'(preset_q[c]);
               SEL_COUNT:  Data_out = 32'(count_q[c]);
               SEL_STAT:   Data_out = {31'b0, pend_q[c]};
            endcase
         end
      end
   end

   always_comb begin
      IRQ_vec = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         IRQ_vec[c] = pend_q[c] & ctrl_q[c][3];
      end
   end

   assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: register-access vector table, hand-written timing sequences,
// and randomized traffic compared against a behavioural model of the channel rules.
module tb_timer_multi;
   localparam int unsigned NCH  = 2;
   localparam int unsigned CW   = 16;
   localparam int unsigned MASK = (1 << CW) - 1;
   localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_DONE = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            Wr_en = 1'b0;
   logic [5:2]      PrAddr = '0;
   logic [31:0]     Data_in = '0;
   logic [31:0]     Data_out;
   logic            IRQ;
   logic [NCH-1:0]  IRQ_vec;

   int checks = 0;
   int errors = 0;

   int unsigned m_ctrl [NCH];
   int unsigned m_pre  [NCH];
   int unsigned m_cnt  [NCH];
   bit          m_pend [NCH];
   int          m_st   [NCH];

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } vec_t;
   vec_t vt [17];

   always #10 clk = ~clk;

   timer_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .PrAddr(PrAddr), .Wr_en(Wr_en),
      .Data_in(Data_in), .Data_out(Data_out), .IRQ(IRQ), .IRQ_vec(IRQ_vec)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock edge of the channel rules: enable arms a load, the load copies PRESET,
   // counting runs down to zero, zero raises PEND and then reloads, stops or wraps.
   function automatic void model_step(input logic w, input logic [3:0] a,
                                      input logic [31:0] d, input logic r);
      for (int unsigned c = 0; c < NCH; c++) begin
         int unsigned nctrl, npre, ncnt, mode;
         int nst;
         bit npend, setp, en;
         if (r) begin
            m_ctrl[c] = 0; m_pre[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_st[c] = ST_IDLE;
            continue;
         end
         nctrl = m_ctrl[c]; npre = m_pre[c]; ncnt = m_cnt[c];
         npend = m_pend[c]; nst = m_st[c]; setp = 0;
         en = m_ctrl[c][0];
         mode = (m_ctrl[c] >> 1) & 3;
         if (m_st[c] == ST_IDLE) begin
            if (en) nst = ST_LOAD;
         end else if (m_st[c] == ST_LOAD) begin
            ncnt = m_pre[c];
            nst = ST_RUN;
         end else if (m_st[c] == ST_RUN) begin
            if (!en) nst = ST_IDLE;
            else begin
               if (m_cnt[c] == 0) begin
                  setp = 1;
                  if (mode != 2) nst = ST_DONE;
               end
               if (m_cnt[c] != 0 || mode == 2) ncnt = (m_cnt[c] - 1) & MASK;
            end
         end else begin
            if (mode == 1) nst = ST_LOAD;
            else begin
               nst = ST_IDLE;
               nctrl = nctrl & ~32'd1;
            end
         end
         if (w && a[3:2] == c[1:0]) begin
            if (a[1:0] == 2'd0) nctrl = 32'(d[3:0]);
            if (a[1:0] == 2'd1) npre = d & MASK;
            if (a[1:0] == 2'd3 && d[0]) npend = 0;
         end
         if (setp) npend = 1;
         m_ctrl[c] = nctrl; m_pre[c] = npre; m_cnt[c] = ncnt; m_pend[c] = npend; m_st[c] = nst;
      end
   endfunction

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      int unsigned ch;
      ch = 32'(a[3:2]);
      if (ch >= NCH) return 32'd0;
      case (a[1:0])
         2'd0: return m_ctrl[ch];
         2'd1: return m_pre[ch];
         2'd2: return m_cnt[ch];
         default: return 32'(m_pend[ch]);
      endcase
   endfunction

   function automatic logic [NCH-1:0] exp_irq();
      logic [NCH-1:0] v;
      for (int unsigned c = 0; c < NCH; c++) v[c] = m_pend[c] & m_ctrl[c][3];
      return v;
   endfunction

   task automatic cyc(input logic w, input logic [3:0] a, input logic [31:0] d, input logic r);
      Wr_en = w; PrAddr = a; Data_in = d; reset = r;
      @(posedge clk);
      model_step(w, a, d, r);
      #1;
      Wr_en = 1'b0; reset = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 4'h0, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
      Wr_en = 1'b0; PrAddr = a;
      #1;
      chk(nm, Data_out, exp);
   endtask

   task automatic do_reset();
      cyc(1'b0, 4'h0, 32'd0, 1'b1);
      cyc(1'b0, 4'h0, 32'd0, 1'b1);
   endtask

   initial begin
      vt[0]  = '{1'b0, 4'b0000, 32'h0,        32'h0,        1'b0};
      vt[1]  = '{1'b1, 4'b0001, 32'hFFFFFFFF, 32'h0,        1'b0};
      vt[2]  = '{1'b0, 4'b0001, 32'h0,        32'h0000FFFF, 1'b0};
      vt[3]  = '{1'b1, 4'b1100, 32'hF,        32'h0,        1'b0};
      vt[4]  = '{1'b0, 4'b1100, 32'h0,        32'h0,        1'b0};
      vt[5]  = '{1'b0, 4'b0100, 32'h0,        32'h0,        1'b0};
      vt[6]  = '{1'b0, 4'b1101, 32'h0,        32'h0,        1'b0};
      vt[7]  = '{1'b1, 4'b0010, 32'h1234,     32'h0,        1'b0};
      vt[8]  = '{1'b0, 4'b0010, 32'h0,        32'h0,        1'b0};
      vt[9]  = '{1'b1, 4'b0100, 32'hFFFFFFF6, 32'h0,        1'b0};
      vt[10] = '{1'b0, 4'b0100, 32'h0,        32'h6,        1'b0};
      vt[11] = '{1'b1, 4'b0100, 32'h8,        32'h6,        1'b0};
      vt[12] = '{1'b0, 4'b0100, 32'h0,        32'h8,        1'b0};
      vt[13] = '{1'b0, 4'b0011, 32'h0,        32'h0,        1'b0};
      vt[14] = '{1'b1, 4'b0001, 32'h0,        32'h0000FFFF, 1'b0};
      vt[15] = '{1'b0, 4'b0001, 32'h0,        32'h0,        1'b0};
      vt[16] = '{1'b0, 4'b1011, 32'h0,        32'h0,        1'b0};

      // Reset state on every address
      do_reset();
      for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, "reset dout");
      chk("reset irq", 32'(IRQ), 32'd0);
      chk("reset irq_vec", 32'(IRQ_vec), 32'd0);

      // Register-access vectors (read data is the value before the edge)
      for (int i = 0; i < 17; i++) begin
         Wr_en = vt[i].wr; PrAddr = vt[i].addr; Data_in = vt[i].data;
         #1;
         chk("vec dout", Data_out, vt[i].exp_dout);
         chk("vec irq", 32'(IRQ), 32'(vt[i].exp_irq));
         cyc(vt[i].wr, vt[i].addr, vt[i].data, 1'b0);
      end

      // One-shot, P=5: PEND/IRQ exactly 8 edges after the CTRL write, EN cleared after
      do_reset();
      cyc(1'b1, 4'b0001, 32'd5, 1'b0);
      cyc(1'b1, 4'b0000, 32'h9, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         cyc(1'b0, 4'h0, 32'd0, 1'b0);
         rd(4'b0010, (k < 2) ? 32'd0 : ((k <= 7) ? 32'(7 - k) : 32'd0), "oneshot count");
         chk("oneshot irq", 32'(IRQ), (k >= 8) ? 32'd1 : 32'd0);
      end
      rd(4'b0000, 32'h8, "oneshot en cleared");
      rd(4'b0011, 32'h1, "oneshot pend");

      // Auto-reload ch1, P=3: period 6; clears at edges 8 and 14, clear at 18 collides with set
      do_reset();
      cyc(1'b1, 4'b0101, 32'd3, 1'b0);
      cyc(1'b1, 4'b0100, 32'hB, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         logic e;
         cyc((k == 8 || k == 14 || k == 18), 4'b0111, 32'd1, 1'b0);
         e = (k >= 6 && k < 8) || (k >= 12 && k < 14) || (k >= 18);
         chk("reload irq_vec", 32'(IRQ_vec), 32'({e, 1'b0}));
         chk("reload irq", 32'(IRQ), 32'(e));
      end

      // Free-run ch0, P=2, IM=0: wrap to all-ones with PEND but no IRQ until IM set
      do_reset();
      cyc(1'b1, 4'b0001, 32'd2, 1'b0);
      cyc(1'b1, 4'b0000, 32'h5, 1'b0);
      idle(4);
      rd(4'b0010, 32'd0, "free count zero");
      rd(4'b0011, 32'd0, "free pend before");
      idle(1);
      rd(4'b0010, 32'h0000FFFF, "free wrap");
      rd(4'b0011, 32'd1, "free pend");
      chk("free irq masked", 32'(IRQ), 32'd0);
      idle(1);
      rd(4'b0010, 32'h0000FFFE, "free after wrap");
      cyc(1'b1, 4'b0000, 32'hD, 1'b0);
      rd(4'b0010, 32'h0000FFFD, "free im no restart");
      chk("free irq unmasked", 32'(IRQ), 32'd1);

      // Disable mid-count at 4, COUNT write ignored, re-enable reloads PRESET
      do_reset();
      cyc(1'b1, 4'b0001, 32'd6, 1'b0);
      cyc(1'b1, 4'b0000, 32'h1, 1'b0);
      idle(3);
      cyc(1'b1, 4'b0000, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         rd(4'b0010, 32'd4, "hold count");
      end
      cyc(1'b1, 4'b0010, 32'h55, 1'b0);
      rd(4'b0010, 32'd4, "count write ignored");
      cyc(1'b1, 4'b0000, 32'h1, 1'b0);
      idle(1);
      rd(4'b0010, 32'd4, "load pending");
      idle(1);
      rd(4'b0010, 32'd6, "reload preset");
      cyc(1'b1, 4'b0001, 32'd9, 1'b0);
      rd(4'b0010, 32'd5, "preset write no effect");
      idle(1);
      rd(4'b0010, 32'd4, "count continues");
      rd(4'b0001, 32'd9, "new preset");

      // PRESET=0 one-shot; CPU CTRL write collides with hardware EN clear
      do_reset();
      cyc(1'b1, 4'b0000, 32'h9, 1'b0);
      idle(2);
      rd(4'b0011, 32'd0, "p0 pend early");
      idle(1);
      rd(4'b0011, 32'd1, "p0 pend");
      chk("p0 irq", 32'(IRQ), 32'd1);
      cyc(1'b1, 4'b0000, 32'hB, 1'b0);
      rd(4'b0000, 32'hB, "cpu ctrl wins");

      // Reset mid-count at COUNT=3, together with a CTRL write
      do_reset();
      cyc(1'b1, 4'b0001, 32'd6, 1'b0);
      cyc(1'b1, 4'b0000, 32'h9, 1'b0);
      idle(5);
      rd(4'b0010, 32'd3, "pre-reset count");
      cyc(1'b1, 4'b0000, 32'hF, 1'b1);
      for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, "midreset dout");
      for (int k = 0; k < 10; k++) begin
         idle(1);
         chk("post-reset irq", 32'(IRQ), 32'd0);
         rd(4'b0011, 32'd0, "post-reset pend");
      end

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         logic w, r;
         logic [3:0] a;
         logic [31:0] d;
         w = ($urandom_range(0, 3) == 0);
         a = 4'($urandom);
         d = $urandom;
         if (a[1:0] == 2'd1) d = $urandom_range(0, 12);
         if (a[1:0] == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         r = ($urandom_range(0, 299) == 0);
         Wr_en = w; PrAddr = a; Data_in = d; reset = r;
         #1;
         chk("rand dout", Data_out, exp_rd(a));
         chk("rand irq_vec", 32'(IRQ_vec), 32'(exp_irq()));
         chk("rand irq", 32'(IRQ), 32'(|exp_irq()));
         cyc(w, a, d, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent timer channels (legal range 1..4).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the counter and preset width in bits (legal range 8..32).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-005 The block SHALL have port PrAddr, input, [5:2], meaning register address: [5:4] is the channel index, [3:2] is the register select.
REQ-006 The block SHALL have port Wr_en, input, 1 bit, meaning write strobe for the addressed register.
REQ-007 The block SHALL have port Data_in, input, 32 bits, meaning write data.
REQ-008 The block SHALL have port Data_out, output, 32 bits, meaning combinational read data of the addressed register.
REQ-009 The block SHALL have port IRQ, output, 1 bit, meaning the OR of all channel interrupts.
REQ-010 The block SHALL have port IRQ_vec, output, NUM_CH bits, meaning per-channel interrupt, bit c = PEND[c] & IM[c].

Function
REQ-011 Per-channel registers SHALL be selected by [3:2]: 0 CTRL (R/W), 1 PRESET (R/W), 2 COUNT (read-only), 3 STAT (bit0 PEND, write-1-to-clear).
REQ-012 CTRL SHALL be bits [3:0]: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10 free-run, 11 treated as one-shot), bit3 IM; read bits [31:4] as 0.
REQ-013 PRESET writes SHALL take Data_in[CNT_W-1:0]; PRESET and COUNT reads SHALL be zero-extended to 32 bits.
REQ-014 Writes to COUNT, and writes to or reads from channel index >= NUM_CH, SHALL be ignored, with reads returning 0.
REQ-015 Each channel SHALL run an FSM with states IDLE, LOAD, CNT, DONE.
REQ-016 In IDLE, when EN=1, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE with COUNT held.
REQ-017 In LOAD, the channel SHALL set COUNT <= PRESET and go to CNT.
REQ-018 In CNT with EN=0, the FSM SHALL go to IDLE with COUNT held.
REQ-019 In CNT with EN=1 and COUNT != 0, the channel SHALL set COUNT <= COUNT-1.
REQ-020 In CNT with EN=1 and COUNT == 0, the channel SHALL set PEND.
REQ-021 At that COUNT == 0 event in modes 00/01/11 the FSM SHALL go to DONE; in mode 10 the channel SHALL set COUNT <= all-ones (wrap) and remain in CNT.
REQ-022 In DONE with mode 01, the FSM SHALL go to LOAD.
REQ-023 In DONE with mode 00/11, the hardware SHALL clear EN and the FSM SHALL go to IDLE.
REQ-024 Timing SHALL be: CTRL write with EN=1 at edge 0 gives LOAD state after edge 1, COUNT=P after edge 2, COUNT=0 after edge 2+P, PEND=1 after edge 3+P; the auto-reload period SHALL be P+3 cycles; PRESET=0 SHALL give PEND after edge 3.
REQ-025 A PRESET write during CNT SHALL NOT alter COUNT; it SHALL take effect at the next LOAD.
REQ-026 A CTRL write changing MODE or IM during CNT SHALL NOT restart the count; the new MODE SHALL apply at the next COUNT == 0 event.
REQ-027 When a CPU CTRL write and the one-shot hardware EN-clear occur in the same cycle, the CPU write value SHALL win; the FSM SHALL still go to IDLE.
REQ-028 When a STAT write-1-to-clear and a hardware PEND set occur in the same cycle, the set SHALL win.
REQ-029 IRQ and IRQ_vec SHALL be combinational from registered PEND and IM only, and SHALL remain asserted until PEND is cleared or IM=0.
REQ-030 Channels SHALL be fully independent; simultaneous events on different channels SHALL all take effect.

Reset
REQ-031 When reset=1 at a clock edge, all CTRL, PRESET, COUNT and PEND registers SHALL be set to 0 and every FSM to IDLE, overriding any write or count in the same cycle.
REQ-032 After reset, IRQ SHALL be 0, IRQ_vec SHALL be 0, and Data_out SHALL be 0 for every address.
REQ-033 A reset asserted mid-count SHALL abort the count with no PEND raised.

Verification
REQ-034 The bench SHALL cover: ch0 PRESET=5, CTRL=0x9 (one-shot, IM) -> COUNT 5,4..0, PEND and IRQ high exactly 8 cycles after the CTRL write edge, EN reads 0 afterwards.
REQ-035 The bench SHALL cover: ch1 PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ_vec[1] set every 6 cycles; STAT write 1 clears it in between; a clear coinciding with a set leaves PEND=1.
REQ-036 The bench SHALL cover: ch0 PRESET=2, CTRL=0x5 (free-run, IM=0) -> after 0, COUNT wraps to 2^CNT_W-1, PEND=1, IRQ stays 0; a later IM=1 write raises IRQ.
REQ-037 The bench SHALL cover: CTRL EN=0 written mid-count at COUNT=4 -> COUNT holds 4 in IDLE; EN=1 reloads PRESET, not 4.
REQ-038 The bench SHALL cover: a COUNT write, a channel-3 access with NUM_CH=2, and a PRESET write of 0xFFFFFFFF with CNT_W=16 -> COUNT unchanged, read 0, PRESET reads 0x0000FFFF.
REQ-039 The bench SHALL cover: reset pulsed while ch0 is at COUNT=3 -> all registers 0, IRQ 0, no PEND on the following cycles.
